even_bit_window_acc: RTL and testbench



---
 rtl/even_bit_window_acc_if.sv | 22 ++
 rtl/even_bit_window_acc.sv | 104 ++++++++++
 tb/tb_even_bit_window_acc.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/even_bit_window_acc_if.sv
// Handshake bundle for even_bit_window_acc: upstream sample port (c/dav_/rfd)
// and downstream result port (sum/max/err/dav_out_/rfd_out).
interface even_bit_window_acc_if;
    logic [2:0] c;
    logic       dav_;
    logic       rfd;
    logic [7:0] sum;
    logic [2:0] max;
    logic       err;
    logic       dav_out_;
    logic       rfd_out;

    modport master (
        output c, dav_, rfd_out,
        input  rfd, sum, max, err, dav_out_
    );

    modport slave (
        input  c, dav_, rfd_out,
        output rfd, sum, max, err, dav_out_
    );
endinterface

// File: rtl/even_bit_window_acc.sv
// Accumulates N upstream samples into sum/max/err and hands the window result downstream.
// Optional macro EVEN_BIT_WINDOW_MAX_EN enables window-maximum tracking (max tied to 0 otherwise).
module even_bit_window_acc #(
    parameter int unsigned N = 4
) (
    input logic            clock,
    input logic            reset,
    even_bit_window_acc_if.slave bus
);
    typedef enum logic [2:0] {
        S_RX  = 3'd0,
        S_ACK = 3'd1,
        S_ACC = 3'd2,
        S_OUT = 3'd3,
        S_REL = 3'd4
    } state_t;

    localparam logic [5:0] LAST = 6'(N - 1);

    state_t     star;
    logic [2:0] sample;
    logic [5:0] cnt;
    logic [7:0] sum_r;
    logic       err_r;
    logic       rfd_r;
    logic       dav_out_r;

    assign bus.rfd      = rfd_r;
    assign bus.dav_out_ = dav_out_r;
    assign bus.sum      = sum_r;
    assign bus.err      = err_r;

`ifdef EVEN_BIT_WINDOW_MAX_EN
    logic [2:0] max_r;

    assign bus.max = max_r;

    // Max shares the FSM's accumulate and release edges, so it is kept in step here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            max_r <= '0;
        end else if (star == S_ACC) begin
            if (sample > max_r) max_r <= sample;
        end else if (star == S_REL && bus.rfd_out) begin
            max_r <= '0;
        end
    end
`else
    assign bus.max = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            star      <= S_RX;
            sample    <= '0;
            cnt       <= '0;
            sum_r     <= '0;
            err_r     <= 1'b0;
            rfd_r     <= 1'b1;
            dav_out_r <= 1'b1;
        end else begin
            case (star)
                S_RX: begin
                    if (!bus.dav_) begin
                        sample <= bus.c;
                        rfd_r  <= 1'b0;
                        star   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (bus.dav_) star <= S_ACC;
                end
                S_ACC: begin
                    sum_r <= sum_r + {5'b0, sample};
                    err_r <= err_r | (sample > 3'd4);
                    cnt   <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        dav_out_r <= 1'b0;
                        star      <= S_OUT;
                    end else begin
                        rfd_r <= 1'b1;
                        star  <= S_RX;
                    end
                end
                S_OUT: begin
                    if (!bus.rfd_out) begin
                        dav_out_r <= 1'b1;
                        star      <= S_REL;
                    end
                end
                S_REL: begin
                    if (bus.rfd_out) begin
                        sum_r <= '0;
                        err_r <= 1'b0;
                        cnt   <= '0;
                        rfd_r <= 1'b1;
                        star  <= S_RX;
                    end
                end
                default: star <= S_RX;
            endcase
        end
    end
endmodule

// File: tb/tb_even_bit_window_acc.sv
// Directed self-checking bench for even_bit_window_acc (N=4 and N=1 instances).
module tb_even_bit_window_acc;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    even_bit_window_acc_if bus4 ();
    even_bit_window_acc_if bus1 ();

    even_bit_window_acc #(.N(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
    even_bit_window_acc #(.N(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] emax(input logic [2:0] m);
`ifdef EVEN_BIT_WINDOW_MAX_EN
        return m;
`else
        return 3'd0;
`endif
    endfunction

    task automatic wait_rfd(input logic v, input string tag);
        for (int i = 0; i < 50 && bus4.rfd !== v; i++) begin
            @(posedge clock); #1;
        end
        chk(tag, bus4.rfd, v);
    endtask

    task automatic wait_dav_out(input logic v, input string tag);
        for (int i = 0; i < 50 && bus4.dav_out_ !== v; i++) begin
            @(posedge clock); #1;
        end
        chk(tag, bus4.dav_out_, v);
    endtask

    task automatic send(input logic [2:0] v);
        wait_rfd(1'b1, "rfd_idle");
        bus4.c    = v;
        bus4.dav_ = 1'b0;
        wait_rfd(1'b0, "rfd_capture");
        bus4.dav_ = 1'b1;
    endtask

    task automatic send4(input logic [2:0] a, b, d, e);
        send(a); send(b); send(d); send(e);
    endtask

    task automatic drain(input logic [7:0] s, input logic [2:0] m, input logic e, input string tag);
        wait_dav_out(1'b0, {tag, "_dav_lo"});
        chk({tag, "_sum"}, bus4.sum, s);
        chk({tag, "_max"}, bus4.max, emax(m));
        chk({tag, "_err"}, bus4.err, e);
        chk({tag, "_rfd_busy"}, bus4.rfd, 1'b0);
        bus4.rfd_out = 1'b0;
        wait_dav_out(1'b1, {tag, "_dav_hi"});
        @(posedge clock); #1;
        bus4.rfd_out = 1'b1;
        wait_rfd(1'b1, {tag, "_rfd_back"});
        chk({tag, "_sum_clr"}, bus4.sum, 8'd0);
        chk({tag, "_max_clr"}, bus4.max, 3'd0);
        chk({tag, "_err_clr"}, bus4.err, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus4.c = '0; bus4.dav_ = 1'b1; bus4.rfd_out = 1'b1;
        bus1.c = '0; bus1.dav_ = 1'b1; bus1.rfd_out = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rfd", bus4.rfd, 1'b1);
        chk("rst_dav_out", bus4.dav_out_, 1'b1);
        chk("rst_sum", bus4.sum, 8'd0);
        chk("rst_max", bus4.max, 3'd0);
        chk("rst_err", bus4.err, 1'b0);
        reset = 1'b0;

        // Basic window 1,2,3,4
        send4(3'd1, 3'd2, 3'd3, 3'd4);
        drain(8'd10, 3'd4, 1'b0, "w1234");

        // Downstream stall with upstream offering a sample meanwhile
        send4(3'd2, 3'd2, 3'd2, 3'd2);
        wait_dav_out(1'b0, "stall_dav_lo");
        bus4.c = 3'd4; bus4.dav_ = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            chk("stall_dav_out", bus4.dav_out_, 1'b0);
            chk("stall_rfd", bus4.rfd, 1'b0);
            chk("stall_sum", bus4.sum, 8'd8);
            chk("stall_max", bus4.max, emax(3'd2));
        end
        bus4.dav_ = 1'b1;
        @(posedge clock); #1;
        drain(8'd8, 3'd2, 1'b0, "stall");
        send4(3'd1, 3'd1, 3'd1, 3'd1);
        drain(8'd4, 3'd1, 1'b0, "after_stall");

        // Out-of-range sample then a clean window
        send4(3'd0, 3'd7, 3'd0, 3'd0);
        drain(8'd7, 3'd7, 1'b1, "w0700");
        send4(3'd1, 3'd1, 3'd1, 3'd1);
        drain(8'd4, 3'd1, 1'b0, "w1111");

        // Asynchronous reset mid-window
        send(3'd3); send(3'd3);
        wait_rfd(1'b1, "mid_rfd");
        repeat (2) @(posedge clock);
        #1;
        chk("mid_sum", bus4.sum, 8'd6);
        reset = 1'b1;
        #1;
        chk("arst_rfd", bus4.rfd, 1'b1);
        chk("arst_dav_out", bus4.dav_out_, 1'b1);
        chk("arst_sum", bus4.sum, 8'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        send4(3'd1, 3'd1, 3'd1, 3'd1);
        drain(8'd4, 3'd1, 1'b0, "post_rst");

        // N=1 exact timing of the accumulate edge
        bus1.c = 3'd2; bus1.dav_ = 1'b0;
        @(posedge clock); #1;
        chk("n1_rfd_lo", bus1.rfd, 1'b0);
        bus1.dav_ = 1'b1;
        @(posedge clock); #1;
        chk("n1_dav_out_wait", bus1.dav_out_, 1'b1);
        chk("n1_sum_wait", bus1.sum, 8'd0);
        @(posedge clock); #1;
        chk("n1_dav_out_lo", bus1.dav_out_, 1'b0);
        chk("n1_sum", bus1.sum, 8'd2);
        chk("n1_max", bus1.max, emax(3'd2));
        chk("n1_rfd_busy", bus1.rfd, 1'b0);
        bus1.rfd_out = 1'b0;
        @(posedge clock); #1;
        chk("n1_dav_out_hi", bus1.dav_out_, 1'b1);
        bus1.rfd_out = 1'b1;
        @(posedge clock); #1;
        chk("n1_rfd_back", bus1.rfd, 1'b1);
        chk("n1_sum_clr", bus1.sum, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
